// File: rtl/qduc_pkg.sv
// Shared types for the quadrature upconverter configuration sequencer:
// the sequencer state, the configuration record and timer sizing helpers.
package qduc_pkg;

   localparam int FSZ_DEFAULT = 31;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUTE,
      ST_COMMIT,
      ST_FLUSH,
      ST_SETTLE
   } state_t;

   // One record serves as both the shadow copy and the committed copy.
   typedef struct packed {
      logic [FSZ_DEFAULT-1:0] lo_freq;
      logic                   lo_dir;
      logic                   lo_ns_en;
      logic                   iq_swap;
      logic                   tuner_byp;
      logic                   flush;
   } cfg_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Counter width for loads up to n-1; never narrower than one bit.
   function automatic int timer_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/qduc_ctrl_timer.sv
// Loadable down-counter with a zero flag; it stops at zero and holds there
// until the next load.
module qduc_ctrl_timer #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/qduc_ctrl.sv
// Glitch-free configuration sequencer for the quadrature upconverter:
// mute, drain, commit on an input strobe, optional DSP reset, settle, unmute.
module qduc_ctrl
   import qduc_pkg::*;
#(
   parameter int FSZ           = FSZ_DEFAULT,
   parameter int MUTE_CYCLES   = 256,
   parameter int RST_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 1024
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           in_strobe,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [FSZ-1:0] cfg_lo_freq,
   input  logic           cfg_lo_dir,
   input  logic           cfg_lo_ns_en,
   input  logic           cfg_iq_swap,
   input  logic           cfg_tuner_byp,
   input  logic           cfg_flush,
   output logic [FSZ-1:0] lo_freq,
   output logic           lo_dir,
   output logic           lo_ns_en,
   output logic           iq_swap,
   output logic           tuner_byp,
   output logic           dsp_reset,
   output logic           mute,
   output logic           busy,
   output logic           applied
);

   localparam int TW = timer_width(max3(MUTE_CYCLES, RST_CYCLES, SETTLE_CYCLES));

   localparam logic [TW-1:0] MUTE_LD   = TW'(MUTE_CYCLES - 1);
   localparam logic [TW-1:0] RST_LD    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

   state_t        state;
   state_t        state_nxt;
   cfg_t          cfg_in;
   cfg_t          shadow;
   cfg_t          committed;
   logic          take;
   logic          commit;
   logic          done;
   logic          t_load;
   logic [TW-1:0] t_val;
   logic          t_zero;

   // Post-reset the timer starts loaded so the chain drains before first use.
   qduc_ctrl_timer #(
      .W       (TW),
      .RST_VAL (SETTLE_LD)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (t_load),
      .load_val (t_val),
      .zero     (t_zero)
   );

   always_comb begin
      cfg_in           = '0;
      cfg_in.lo_freq   = FSZ_DEFAULT'(cfg_lo_freq);
      cfg_in.lo_dir    = cfg_lo_dir;
      cfg_in.lo_ns_en  = cfg_lo_ns_en;
      cfg_in.iq_swap   = cfg_iq_swap;
      cfg_in.tuner_byp = cfg_tuner_byp;
      cfg_in.flush     = cfg_flush;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_SETTLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      commit    = 1'b0;
      done      = 1'b0;
      t_load    = 1'b0;
      t_val     = '0;
      unique case (state)
         ST_IDLE: begin
            if (cfg_valid) begin
               take      = 1'b1;
               t_load    = 1'b1;
               t_val     = MUTE_LD;
               state_nxt = ST_MUTE;
            end
         end
         ST_MUTE: begin
            if (t_zero) begin
               state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            // Strobes seen while still muting are deliberately not remembered.
            if (in_strobe) begin
               commit = 1'b1;
               t_load = 1'b1;
               if (shadow.flush) begin
                  t_val     = RST_LD;
                  state_nxt = ST_FLUSH;
               end else begin
                  t_val     = SETTLE_LD;
                  state_nxt = ST_SETTLE;
               end
            end
         end
         ST_FLUSH: begin
            if (t_zero) begin
               t_load    = 1'b1;
               t_val     = SETTLE_LD;
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (t_zero) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            t_load    = 1'b1;
            t_val     = SETTLE_LD;
            state_nxt = ST_SETTLE;
         end
      endcase
   end

   // NOTE: shadow and committed are plain registers, not RAM, so they take
   // the reset and a mid-sequence reset discards any pending configuration.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow    <= '0;
         committed <= '0;
         applied   <= 1'b0;
      end else begin
         if (take) begin
            shadow <= cfg_in;
         end
         if (commit) begin
            committed <= shadow;
         end
         applied <= done;
      end
   end

   assign cfg_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign mute      = (state != ST_IDLE);
   assign dsp_reset = (state == ST_FLUSH);

   assign lo_freq   = FSZ'(committed.lo_freq);
   assign lo_dir    = committed.lo_dir;
   assign lo_ns_en  = committed.lo_ns_en;
   assign iq_swap   = committed.iq_swap;
   assign tuner_byp = committed.tuner_byp;

endmodule

// File: tb/tb_qduc_ctrl.sv
// Self-checking bench for qduc_ctrl: expected configurations are queued when
// offered and compared against the outputs at the cycle they are committed.
module tb_qduc_ctrl;
   import qduc_pkg::*;

   localparam int FSZ = 31;
   localparam int M   = 4;
   localparam int R   = 2;
   localparam int S   = 8;

   // {mute, busy, cfg_ready, applied, dsp_reset}
   localparam logic [4:0] V_IDLE = 5'b00100;
   localparam logic [4:0] V_DONE = 5'b00110;
   localparam logic [4:0] V_BUSY = 5'b11000;
   localparam logic [4:0] V_RST  = 5'b11001;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_strobe;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [FSZ-1:0] cfg_lo_freq;
   logic           cfg_lo_dir;
   logic           cfg_lo_ns_en;
   logic           cfg_iq_swap;
   logic           cfg_tuner_byp;
   logic           cfg_flush;
   logic [FSZ-1:0] lo_freq;
   logic           lo_dir;
   logic           lo_ns_en;
   logic           iq_swap;
   logic           tuner_byp;
   logic           dsp_reset;
   logic           mute;
   logic           busy;
   logic           applied;

   logic [4:0]     stat;
   cfg_t           sb_q[$];
   cfg_t           committed_exp;
   cfg_t           want;
   int             tests_run;
   int             tests_failed;

   qduc_ctrl #(
      .FSZ           (FSZ),
      .MUTE_CYCLES   (M),
      .RST_CYCLES    (R),
      .SETTLE_CYCLES (S)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_strobe     (in_strobe),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_lo_freq   (cfg_lo_freq),
      .cfg_lo_dir    (cfg_lo_dir),
      .cfg_lo_ns_en  (cfg_lo_ns_en),
      .cfg_iq_swap   (cfg_iq_swap),
      .cfg_tuner_byp (cfg_tuner_byp),
      .cfg_flush     (cfg_flush),
      .lo_freq       (lo_freq),
      .lo_dir        (lo_dir),
      .lo_ns_en      (lo_ns_en),
      .iq_swap       (iq_swap),
      .tuner_byp     (tuner_byp),
      .dsp_reset     (dsp_reset),
      .mute          (mute),
      .busy          (busy),
      .applied       (applied)
   );

   always #5 clk = ~clk;

   assign stat = {mute, busy, cfg_ready, applied, dsp_reset};

   function automatic cfg_t observed();
      cfg_t o;
      o           = '0;
      o.lo_freq   = lo_freq;
      o.lo_dir    = lo_dir;
      o.lo_ns_en  = lo_ns_en;
      o.iq_swap   = iq_swap;
      o.tuner_byp = tuner_byp;
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive an offer and queue the outputs it should eventually produce.
   task automatic offer(input cfg_t c);
      cfg_t e;
      cfg_lo_freq   = c.lo_freq;
      cfg_lo_dir    = c.lo_dir;
      cfg_lo_ns_en  = c.lo_ns_en;
      cfg_iq_swap   = c.iq_swap;
      cfg_tuner_byp = c.tuner_byp;
      cfg_flush     = c.flush;
      cfg_valid     = 1'b1;
      e             = c;
      e.flush       = 1'b0;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      tests_run++;
      if (stat !== V_BUSY) begin
         tests_failed++;
         $display("FAIL reset_status: got %b want %b", stat, V_BUSY);
      end
      tests_run++;
      if (observed() !== cfg_t'('0)) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h want 0", observed());
      end
      reset = 1'b0;
      for (int i = 0; i < S; i++) begin
         tests_run++;
         if (stat !== V_BUSY) begin
            tests_failed++;
            $display("FAIL post_reset_settle[%0d]: got %b want %b", i, stat, V_BUSY);
         end
         tick();
      end
      tests_run++;
      if (stat !== V_DONE) begin
         tests_failed++;
         $display("FAIL post_reset_applied: got %b want %b", stat, V_DONE);
      end
      tests_run++;
      if (observed() !== cfg_t'('0)) begin
         tests_failed++;
         $display("FAIL post_reset_outputs: got %h want 0", observed());
      end
      tick();
      tests_run++;
      if (stat !== V_IDLE) begin
         tests_failed++;
         $display("FAIL post_reset_idle: got %b want %b", stat, V_IDLE);
      end
   endtask

   task automatic test_basic_retune();
      cfg_t c;
      c         = '0;
      c.lo_freq = 31'h1234567;
      offer(c);
      tick();
      cfg_valid = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tests_run++;
         if (stat !== V_BUSY || observed() !== committed_exp) begin
            tests_failed++;
            $display("FAIL basic_pre_commit[%0d]: got %b/%h want %b/%h",
                     i, stat, observed(), V_BUSY, committed_exp);
         end
         in_strobe = (i == 10);
         tick();
      end
      in_strobe = 1'b0;
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $display("FAIL basic_commit: got empty scoreboard want one entry");
      end else begin
         want = sb_q.pop_front();
         committed_exp = want;
         if (observed() !== want) begin
            tests_failed++;
            $display("FAIL basic_commit: got %h want %h", observed(), want);
         end
      end
      for (int i = 0; i < S; i++) begin
         tests_run++;
         if (stat !== V_BUSY) begin
            tests_failed++;
            $display("FAIL basic_settle[%0d]: got %b want %b", i, stat, V_BUSY);
         end
         tick();
      end
      tests_run++;
      if (stat !== V_DONE) begin
         tests_failed++;
         $display("FAIL basic_applied: got %b want %b", stat, V_DONE);
      end
   endtask

   task automatic test_flush();
      cfg_t c;
      c           = '0;
      c.lo_freq   = 31'h7654321;
      c.tuner_byp = 1'b1;
      c.flush     = 1'b1;
      offer(c);
      tick();
      cfg_valid = 1'b0;
      for (int i = 1; i <= M + 1; i++) begin
         tests_run++;
         if (stat !== V_BUSY || observed() !== committed_exp) begin
            tests_failed++;
            $display("FAIL flush_pre_commit[%0d]: got %b/%h want %b/%h",
                     i, stat, observed(), V_BUSY, committed_exp);
         end
         in_strobe = (i == M + 1);
         tick();
      end
      in_strobe = 1'b0;
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $display("FAIL flush_commit: got empty scoreboard want one entry");
      end else begin
         want = sb_q.pop_front();
         committed_exp = want;
         if (observed() !== want) begin
            tests_failed++;
            $display("FAIL flush_commit: got %h want %h", observed(), want);
         end
      end
      for (int i = 0; i < R; i++) begin
         tests_run++;
         if (stat !== V_RST) begin
            tests_failed++;
            $display("FAIL flush_dsp_reset[%0d]: got %b want %b", i, stat, V_RST);
         end
         tick();
      end
      for (int i = 0; i < S; i++) begin
         tests_run++;
         if (stat !== V_BUSY) begin
            tests_failed++;
            $display("FAIL flush_settle[%0d]: got %b want %b", i, stat, V_BUSY);
         end
         tick();
      end
      tests_run++;
      if (stat !== V_DONE) begin
         tests_failed++;
         $display("FAIL flush_applied: got %b want %b", stat, V_DONE);
      end
   endtask

   task automatic test_back_to_back();
      cfg_t a;
      cfg_t b;
      a          = '0;
      a.lo_freq  = 31'h2AAAAAA;
      a.lo_dir   = 1'b1;
      a.iq_swap  = 1'b1;
      b          = '0;
      b.lo_freq  = 31'h1555555;
      b.lo_ns_en = 1'b1;
      offer(a);
      tick();
      offer(b);
      for (int i = 1; i <= M + 1; i++) begin
         tests_run++;
         if (stat !== V_BUSY || observed() !== committed_exp) begin
            tests_failed++;
            $display("FAIL b2b_first_wait[%0d]: got %b/%h want %b/%h",
                     i, stat, observed(), V_BUSY, committed_exp);
         end
         in_strobe = (i == M + 1);
         tick();
      end
      in_strobe = 1'b0;
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $display("FAIL b2b_first_commit: got empty scoreboard want one entry");
      end else begin
         want = sb_q.pop_front();
         committed_exp = want;
         if (observed() !== want) begin
            tests_failed++;
            $display("FAIL b2b_first_commit: got %h want %h", observed(), want);
         end
      end
      for (int i = 0; i < S; i++) begin
         tests_run++;
         if (stat !== V_BUSY || observed() !== committed_exp) begin
            tests_failed++;
            $display("FAIL b2b_held[%0d]: got %b/%h want %b/%h",
                     i, stat, observed(), V_BUSY, committed_exp);
         end
         tick();
      end
      tests_run++;
      if (stat !== V_DONE || observed() !== committed_exp) begin
         tests_failed++;
         $display("FAIL b2b_first_applied: got %b/%h want %b/%h",
                  stat, observed(), V_DONE, committed_exp);
      end
      tick();
      cfg_valid = 1'b0;
      for (int i = 1; i <= M + 1; i++) begin
         tests_run++;
         if (stat !== V_BUSY || observed() !== committed_exp) begin
            tests_failed++;
            $display("FAIL b2b_second_wait[%0d]: got %b/%h want %b/%h",
                     i, stat, observed(), V_BUSY, committed_exp);
         end
         in_strobe = (i == M + 1);
         tick();
      end
      in_strobe = 1'b0;
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $display("FAIL b2b_second_commit: got empty scoreboard want one entry");
      end else begin
         want = sb_q.pop_front();
         committed_exp = want;
         if (observed() !== want) begin
            tests_failed++;
            $display("FAIL b2b_second_commit: got %h want %h", observed(), want);
         end
      end
      repeat (S) tick();
      tests_run++;
      if (stat !== V_DONE) begin
         tests_failed++;
         $display("FAIL b2b_second_applied: got %b want %b", stat, V_DONE);
      end
   endtask

   task automatic test_strobe_in_mute();
      cfg_t c;
      c           = '0;
      c.lo_freq   = 31'h7FFFFF0;
      c.lo_dir    = 1'b1;
      c.lo_ns_en  = 1'b1;
      c.tuner_byp = 1'b1;
      offer(c);
      tick();
      cfg_valid = 1'b0;
      for (int i = 1; i <= 64; i++) begin
         tests_run++;
         if (stat !== V_BUSY || observed() !== committed_exp) begin
            tests_failed++;
            $display("FAIL strobe_mute_wait[%0d]: got %b/%h want %b/%h",
                     i, stat, observed(), V_BUSY, committed_exp);
         end
         in_strobe = (i == 2 || i == 64);
         tick();
         in_strobe = 1'b0;
      end
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $display("FAIL strobe_mute_commit: got empty scoreboard want one entry");
      end else begin
         want = sb_q.pop_front();
         committed_exp = want;
         if (observed() !== want) begin
            tests_failed++;
            $display("FAIL strobe_mute_commit: got %h want %h", observed(), want);
         end
      end
      repeat (S) tick();
      tests_run++;
      if (stat !== V_DONE) begin
         tests_failed++;
         $display("FAIL strobe_mute_applied: got %b want %b", stat, V_DONE);
      end
   endtask

   task automatic test_mid_reset();
      cfg_t c;
      c         = '0;
      c.lo_freq = 31'h0ABCDEF;
      c.iq_swap = 1'b1;
      c.flush   = 1'b1;
      offer(c);
      tick();
      cfg_valid = 1'b0;
      for (int i = 1; i <= M + 1; i++) begin
         in_strobe = (i == M + 1);
         tick();
      end
      in_strobe = 1'b0;
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $display("FAIL mid_reset_commit: got empty scoreboard want one entry");
      end else begin
         want = sb_q.pop_front();
         if (observed() !== want || stat !== V_RST) begin
            tests_failed++;
            $display("FAIL mid_reset_commit: got %b/%h want %b/%h",
                     stat, observed(), V_RST, want);
         end
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      committed_exp = '0;
      tests_run++;
      if (stat !== V_BUSY || observed() !== committed_exp) begin
         tests_failed++;
         $display("FAIL mid_reset_cleared: got %b/%h want %b/%h",
                  stat, observed(), V_BUSY, committed_exp);
      end
      for (int i = 0; i < S; i++) begin
         tests_run++;
         if (stat !== V_BUSY) begin
            tests_failed++;
            $display("FAIL mid_reset_settle[%0d]: got %b want %b", i, stat, V_BUSY);
         end
         tick();
      end
      tests_run++;
      if (stat !== V_DONE || observed() !== committed_exp) begin
         tests_failed++;
         $display("FAIL mid_reset_applied: got %b/%h want %b/%h",
                  stat, observed(), V_DONE, committed_exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      committed_exp = '0;
      reset         = 1'b1;
      in_strobe     = 1'b0;
      cfg_valid     = 1'b0;
      cfg_lo_freq   = '0;
      cfg_lo_dir    = 1'b0;
      cfg_lo_ns_en  = 1'b0;
      cfg_iq_swap   = 1'b0;
      cfg_tuner_byp = 1'b0;
      cfg_flush     = 1'b0;
      test_reset();
      test_basic_retune();
      test_flush();
      test_back_to_back();
      test_strobe_in_mute();
      test_mid_reset();
      tests_run++;
      if (sb_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
